// File: rtl/compressor_serial_adder.sv
// Bit-serial four-operand adder: one 4:2 compressor column per clock, LSB first,
// with a same-cycle final propagate stage and valid/ready handshakes on both sides.
module compressor_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] op_c,
    input  logic [WIDTH-1:0] op_d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH+1:0] result
);
    localparam int CW = $clog2(WIDTH + 3);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t           state, state_next;
    logic             accept;
    logic [WIDTH-1:0] sa, sb, sc, sd;
    logic [CW-1:0]    col;
    logic             cin_r, cy_r, pc_r;
    logic             s1, co1, s_k, cy_k, res_k, pc_next;

    // 4:2 column cell: fa1 reduces a/b/c, fa2 folds in d and the previous column's co1.
    full_adder fa1 (.a(sa[0]), .b(sb[0]), .ci(sc[0]), .s(s1), .co(co1));
    full_adder fa2 (.a(s1), .b(sd[0]), .ci(cin_r), .s(s_k), .co(cy_k));

    always_comb begin
        res_k   = s_k ^ cy_r ^ pc_r;
        pc_next = (s_k & cy_r) | (s_k & pc_r) | (cy_r & pc_r);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN:  if (col == COL_LAST) state_next = HOLD;
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operands shift in zeros, so the two flush columns see all-zero operand bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            sa     <= '0;
            sb     <= '0;
            sc     <= '0;
            sd     <= '0;
            cin_r  <= 1'b0;
            cy_r   <= 1'b0;
            pc_r   <= 1'b0;
            col    <= '0;
            result <= '0;
        end else if (accept) begin
            sa    <= op_a;
            sb    <= op_b;
            sc    <= op_c;
            sd    <= op_d;
            cin_r <= 1'b0;
            cy_r  <= 1'b0;
            pc_r  <= 1'b0;
            col   <= '0;
        end else if (state == RUN) begin
            sa     <= sa >> 1;
            sb     <= sb >> 1;
            sc     <= sc >> 1;
            sd     <= sd >> 1;
            cin_r  <= co1;
            cy_r   <= cy_k;
            pc_r   <= pc_next;
            col    <= col + 1'b1;
            result <= {res_k, result[WIDTH+1:1]};
        end
    end
endmodule

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule
